// File: rtl/rv_iopmp_err_capture.sv
// IOPMP error-record stage: latches the first write/read violation, counts the rest, drives the wired IRQ.
// Optional message-signalled interrupt path is built when RV_IOPMP_ERR_MSI_EN is defined.
module rv_iopmp_err_capture #(
    parameter int unsigned RRID_W = 16,
    parameter int unsigned EID_W  = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_err_valid_i,
    input  logic [2:0]        wr_err_etype_i,
    input  logic [63:0]       wr_err_addr_i,
    input  logic [RRID_W-1:0] wr_err_rrid_i,
    input  logic [EID_W-1:0]  wr_err_eid_i,
    input  logic              rd_err_valid_i,
    input  logic [1:0]        rd_err_ttype_i,
    input  logic [2:0]        rd_err_etype_i,
    input  logic [63:0]       rd_err_addr_i,
    input  logic [RRID_W-1:0] rd_err_rrid_i,
    input  logic [EID_W-1:0]  rd_err_eid_i,
    input  logic              ie_i,
    input  logic              clr_i,
`ifdef RV_IOPMP_ERR_MSI_EN
    input  logic              msi_en_i,
    input  logic [63:0]       msi_addr_i,
    input  logic [10:0]       msi_data_i,
    output logic              msi_req_o,
    output logic [63:0]       msi_addr_o,
    output logic [10:0]       msi_data_o,
    input  logic              msi_ack_i,
`endif
    output logic              err_v_o,
    output logic [1:0]        err_ttype_o,
    output logic [2:0]        err_etype_o,
    output logic [31:0]       err_reqaddr_o,
    output logic [31:0]       err_reqaddrh_o,
    output logic [RRID_W-1:0] err_rrid_o,
    output logic [EID_W-1:0]  err_eid_o,
    output logic [CNT_W-1:0]  lost_cnt_o,
    output logic              irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HELD     = 2'd1
`ifdef RV_IOPMP_ERR_MSI_EN
        ,
        ST_MSI_PEND = 2'd2
`endif
    } state_e;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                 input logic [1:0]       inc);
        logic [CNT_W+1:0] sum;
        sum = {2'b00, base} + {{CNT_W{1'b0}}, inc};
        if (sum > {2'b00, {CNT_W{1'b1}}}) begin
            return {CNT_W{1'b1}};
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    state_e              state_r;
    state_e              state_next_s;
    state_e              cap_state_s;
    logic                err_v_r;
    logic [1:0]          ttype_r;
    logic [2:0]          etype_r;
    logic [63:0]         addr_r;
    logic [RRID_W-1:0]   rrid_r;
    logic [EID_W-1:0]    eid_r;
    logic [CNT_W-1:0]    lost_cnt_r;

    logic                any_v_s;
    logic                clr_eff_s;
    logic                capture_s;
    logic [1:0]          inc_s;
    logic [CNT_W-1:0]    cnt_next_s;
    logic                err_v_next_s;
    logic [1:0]          sel_ttype_s;
    logic [2:0]          sel_etype_s;
    logic [63:0]         sel_addr_s;
    logic [RRID_W-1:0]   sel_rrid_s;
    logic [EID_W-1:0]    sel_eid_s;

`ifdef RV_IOPMP_ERR_MSI_EN
    logic                msi_req_r;
    logic [63:0]         msi_addr_r;
    logic [10:0]         msi_data_r;
    logic                msi_latch_s;
`endif

    // Next-state, capture decision, saturating lost count and write-first source select.
    always_comb begin
        any_v_s   = wr_err_valid_i | rd_err_valid_i;
        clr_eff_s = clr_i & (state_r != ST_IDLE);
        // A clear frees the record slot in the same cycle, so a coincident report is recorded.
        capture_s = any_v_s & ((state_r == ST_IDLE) | clr_eff_s);
        if (capture_s) begin
            inc_s = {1'b0, wr_err_valid_i & rd_err_valid_i};
        end else begin
            inc_s = {1'b0, wr_err_valid_i} + {1'b0, rd_err_valid_i};
        end
        cnt_next_s   = sat_add(clr_eff_s ? {CNT_W{1'b0}} : lost_cnt_r, inc_s);
        err_v_next_s = capture_s ? 1'b1 : (clr_eff_s ? 1'b0 : err_v_r);

        if (wr_err_valid_i) begin
            sel_ttype_s = 2'd2;
            sel_etype_s = wr_err_etype_i;
            sel_addr_s  = wr_err_addr_i;
            sel_rrid_s  = wr_err_rrid_i;
            sel_eid_s   = wr_err_eid_i;
        end else begin
            sel_ttype_s = rd_err_ttype_i;
            sel_etype_s = rd_err_etype_i;
            sel_addr_s  = rd_err_addr_i;
            sel_rrid_s  = rd_err_rrid_i;
            sel_eid_s   = rd_err_eid_i;
        end

`ifdef RV_IOPMP_ERR_MSI_EN
        cap_state_s = msi_en_i ? ST_MSI_PEND : ST_HELD;
`else
        cap_state_s = ST_HELD;
`endif

        case (state_r)
            ST_IDLE: begin
                state_next_s = capture_s ? cap_state_s : ST_IDLE;
            end
            ST_HELD: begin
                if (capture_s) begin
                    state_next_s = cap_state_s;
                end else if (clr_eff_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HELD;
                end
            end
`ifdef RV_IOPMP_ERR_MSI_EN
            ST_MSI_PEND: begin
                // The message always completes; afterwards the record decides HELD vs IDLE.
                if (msi_ack_i) begin
                    state_next_s = err_v_next_s ? ST_HELD : ST_IDLE;
                end else begin
                    state_next_s = ST_MSI_PEND;
                end
            end
`endif
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

`ifdef RV_IOPMP_ERR_MSI_EN
        msi_latch_s = capture_s & msi_en_i & (state_r != ST_MSI_PEND);
`endif
    end

    // State, record, lost counter and MSI registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= ST_IDLE;
            err_v_r    <= 1'b0;
            ttype_r    <= 2'd0;
            etype_r    <= 3'd0;
            addr_r     <= 64'd0;
            rrid_r     <= {RRID_W{1'b0}};
            eid_r      <= {EID_W{1'b0}};
            lost_cnt_r <= {CNT_W{1'b0}};
`ifdef RV_IOPMP_ERR_MSI_EN
            msi_req_r  <= 1'b0;
            msi_addr_r <= 64'd0;
            msi_data_r <= 11'd0;
`endif
        end else begin
            state_r    <= state_next_s;
            err_v_r    <= err_v_next_s;
            lost_cnt_r <= cnt_next_s;
            if (capture_s) begin
                ttype_r <= sel_ttype_s;
                etype_r <= sel_etype_s;
                addr_r  <= sel_addr_s;
                rrid_r  <= sel_rrid_s;
                eid_r   <= sel_eid_s;
            end
`ifdef RV_IOPMP_ERR_MSI_EN
            msi_req_r <= (state_next_s == ST_MSI_PEND);
            if (msi_latch_s) begin
                msi_addr_r <= msi_addr_i;
                msi_data_r <= msi_data_i;
            end
`endif
        end
    end

    assign err_v_o        = err_v_r;
    assign err_ttype_o    = ttype_r;
    assign err_etype_o    = etype_r;
    assign err_reqaddr_o  = addr_r[31:0];
    assign err_reqaddrh_o = addr_r[63:32];
    assign err_rrid_o     = rrid_r;
    assign err_eid_o      = eid_r;
    assign lost_cnt_o     = lost_cnt_r;

`ifdef RV_IOPMP_ERR_MSI_EN
    assign msi_req_o  = msi_req_r;
    assign msi_addr_o = msi_addr_r;
    assign msi_data_o = msi_data_r;
    assign irq_o      = err_v_r & ie_i & ~msi_en_i;
`else
    assign irq_o      = err_v_r & ie_i;
`endif

endmodule

// File: tb/tb_rv_iopmp_err_capture.sv
// Directed bench for rv_iopmp_err_capture: a default instance plus a CNT_W=2 instance on shared stimulus.
// The MSI scenario is compiled in when RV_IOPMP_ERR_MSI_EN is defined.
module tb_rv_iopmp_err_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_v, rd_v, ie, clr;
    logic [2:0]  wr_etype, rd_etype;
    logic [1:0]  rd_ttype;
    logic [63:0] wr_addr, rd_addr;
    logic [15:0] wr_rrid, rd_rrid, wr_eid, rd_eid;

    logic        err_v, irq, err_v2, irq2;
    logic [1:0]  ttype, ttype2;
    logic [2:0]  etype, etype2;
    logic [31:0] reqaddr, reqaddrh, reqaddr2, reqaddrh2;
    logic [15:0] rrid, eid, rrid2, eid2;
    logic [7:0]  lost;
    logic [1:0]  lost2;

    int checks = 0;
    int errors = 0;

`ifdef RV_IOPMP_ERR_MSI_EN
    logic        msi_en, msi_ack, msi_req, msi_req2;
    logic [63:0] msi_addr_in, msi_addr, msi_addr2;
    logic [10:0] msi_data_in, msi_data, msi_data2;
`endif

    always #5 clk = ~clk;

    rv_iopmp_err_capture u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .wr_err_valid_i(wr_v), .wr_err_etype_i(wr_etype), .wr_err_addr_i(wr_addr),
        .wr_err_rrid_i(wr_rrid), .wr_err_eid_i(wr_eid),
        .rd_err_valid_i(rd_v), .rd_err_ttype_i(rd_ttype), .rd_err_etype_i(rd_etype),
        .rd_err_addr_i(rd_addr), .rd_err_rrid_i(rd_rrid), .rd_err_eid_i(rd_eid),
        .ie_i(ie), .clr_i(clr),
`ifdef RV_IOPMP_ERR_MSI_EN
        .msi_en_i(msi_en), .msi_addr_i(msi_addr_in), .msi_data_i(msi_data_in),
        .msi_req_o(msi_req), .msi_addr_o(msi_addr), .msi_data_o(msi_data), .msi_ack_i(msi_ack),
`endif
        .err_v_o(err_v), .err_ttype_o(ttype), .err_etype_o(etype),
        .err_reqaddr_o(reqaddr), .err_reqaddrh_o(reqaddrh),
        .err_rrid_o(rrid), .err_eid_o(eid), .lost_cnt_o(lost), .irq_o(irq)
    );

    rv_iopmp_err_capture #(.CNT_W(2)) u_dut_c2 (
        .clk_i(clk), .rst_ni(rst_n),
        .wr_err_valid_i(wr_v), .wr_err_etype_i(wr_etype), .wr_err_addr_i(wr_addr),
        .wr_err_rrid_i(wr_rrid), .wr_err_eid_i(wr_eid),
        .rd_err_valid_i(rd_v), .rd_err_ttype_i(rd_ttype), .rd_err_etype_i(rd_etype),
        .rd_err_addr_i(rd_addr), .rd_err_rrid_i(rd_rrid), .rd_err_eid_i(rd_eid),
        .ie_i(ie), .clr_i(clr),
`ifdef RV_IOPMP_ERR_MSI_EN
        .msi_en_i(msi_en), .msi_addr_i(msi_addr_in), .msi_data_i(msi_data_in),
        .msi_req_o(msi_req2), .msi_addr_o(msi_addr2), .msi_data_o(msi_data2), .msi_ack_i(msi_ack),
`endif
        .err_v_o(err_v2), .err_ttype_o(ttype2), .err_etype_o(etype2),
        .err_reqaddr_o(reqaddr2), .err_reqaddrh_o(reqaddrh2),
        .err_rrid_o(rrid2), .err_eid_o(eid2), .lost_cnt_o(lost2), .irq_o(irq2)
    );

    // Advance one clock edge and settle just after it; valids and clear are one-cycle pulses.
    task automatic step();
        @(posedge clk);
        #1;
        wr_v = 1'b0;
        rd_v = 1'b0;
        clr  = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (err_v !== 1'b0 || irq !== 1'b0 || lost !== 8'd0 || ttype !== 2'd0 || etype !== 3'd0 ||
            reqaddr !== 32'd0 || reqaddrh !== 32'd0 || rrid !== 16'd0 || eid !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: v=%0b irq=%0b lost=%0d ttype=%0d etype=%0d addr=%h_%h rrid=%0d eid=%0d, required all 0",
                     err_v, irq, lost, ttype, etype, reqaddrh, reqaddr, rrid, eid);
        end
`ifdef RV_IOPMP_ERR_MSI_EN
        checks++;
        if (msi_req !== 1'b0 || msi_addr !== 64'd0 || msi_data !== 11'd0) begin
            errors++;
            $display("FAIL reset_msi: req=%0b addr=%h data=%h, required 0", msi_req, msi_addr, msi_data);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_capture();
        ie = 1'b1;
        wr_v = 1'b1; wr_etype = 3'd2; wr_addr = 64'h1_2345_6780; wr_rrid = 16'd5; wr_eid = 16'd3;
        step();
        checks++;
        if (err_v !== 1'b1 || reqaddr !== 32'h2345_6780 || reqaddrh !== 32'h1 || ttype !== 2'd2 ||
            etype !== 3'd2 || rrid !== 16'd5 || eid !== 16'd3 || irq !== 1'b1 || lost !== 8'd0) begin
            errors++;
            $display("FAIL capture_wr: v=%0b addr=%h_%h ttype=%0d etype=%0d rrid=%0d eid=%0d irq=%0b lost=%0d, required 1 00000001_23456780 2 2 5 3 1 0",
                     err_v, reqaddrh, reqaddr, ttype, etype, rrid, eid, irq, lost);
        end
        ie = 1'b0;
        #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_ie_off: irq=%0b, required 0", irq);
        end
        ie = 1'b1;
        #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_ie_on: irq=%0b, required 1", irq);
        end
    endtask

    task automatic test_async_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (err_v !== 1'b0 || irq !== 1'b0 || reqaddr !== 32'd0 || reqaddrh !== 32'd0 || ttype !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: v=%0b irq=%0b addr=%h_%h ttype=%0d, required 0", err_v, irq, reqaddrh, reqaddr, ttype);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_simultaneous();
        wr_v = 1'b1; wr_etype = 3'd4; wr_addr = 64'hA_0000_0010; wr_rrid = 16'd7; wr_eid = 16'd9;
        rd_v = 1'b1; rd_etype = 3'd1; rd_ttype = 2'd1; rd_addr = 64'h20; rd_rrid = 16'd8; rd_eid = 16'd1;
        step();
        checks++;
        if (err_v !== 1'b1 || ttype !== 2'd2 || etype !== 3'd4 || reqaddr !== 32'h10 || reqaddrh !== 32'hA ||
            rrid !== 16'd7 || eid !== 16'd9 || lost !== 8'd1 || lost2 !== 2'd1) begin
            errors++;
            $display("FAIL simul_wr_wins: v=%0b ttype=%0d etype=%0d addr=%h_%h rrid=%0d eid=%0d lost=%0d lost2=%0d, required 1 2 4 0000000a_00000010 7 9 1 1",
                     err_v, ttype, etype, reqaddrh, reqaddr, rrid, eid, lost, lost2);
        end
        for (int i = 0; i < 3; i++) begin
            rd_v = 1'b1; rd_addr = 64'h300 + 64'(i); rd_ttype = 2'd3; rd_etype = 3'd5;
            step();
        end
        checks++;
        if (lost !== 8'd4 || lost2 !== 2'd3 || reqaddr !== 32'h10 || ttype !== 2'd2 || etype !== 3'd4) begin
            errors++;
            $display("FAIL held_rd_lost: lost=%0d lost2=%0d addr=%h ttype=%0d etype=%0d, required 4 3 00000010 2 4",
                     lost, lost2, reqaddr, ttype, etype);
        end
        wr_v = 1'b1; rd_v = 1'b1;
        step();
        checks++;
        if (lost !== 8'd6 || lost2 !== 2'd3) begin
            errors++;
            $display("FAIL held_wr_rd_adds_2: lost=%0d lost2=%0d, required 6 3", lost, lost2);
        end
    endtask

    task automatic test_clr_with_valid();
        clr = 1'b1;
        rd_v = 1'b1; rd_ttype = 2'd3; rd_etype = 3'd5; rd_addr = 64'h80; rd_rrid = 16'd2; rd_eid = 16'd6;
        step();
        checks++;
        if (err_v !== 1'b1 || ttype !== 2'd3 || etype !== 3'd5 || reqaddr !== 32'h80 || reqaddrh !== 32'd0 ||
            rrid !== 16'd2 || eid !== 16'd6 || lost !== 8'd0 || lost2 !== 2'd0) begin
            errors++;
            $display("FAIL clr_with_rd: v=%0b ttype=%0d etype=%0d addr=%h_%h rrid=%0d eid=%0d lost=%0d lost2=%0d, required 1 3 5 00000000_00000080 2 6 0 0",
                     err_v, ttype, etype, reqaddrh, reqaddr, rrid, eid, lost, lost2);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            rd_v = 1'b1; rd_addr = 64'h900;
            step();
        end
        checks++;
        if (lost2 !== 2'd3 || lost !== 8'd5) begin
            errors++;
            $display("FAIL sat_small: lost2=%0d lost=%0d, required 3 5", lost2, lost);
        end
        for (int i = 0; i < 126; i++) begin
            wr_v = 1'b1; rd_v = 1'b1;
            step();
        end
        checks++;
        if (lost !== 8'd255 || lost2 !== 2'd3 || reqaddr !== 32'h80 || ttype !== 2'd3) begin
            errors++;
            $display("FAIL sat_full: lost=%0d lost2=%0d addr=%h ttype=%0d, required 255 3 00000080 3",
                     lost, lost2, reqaddr, ttype);
        end
    endtask

    task automatic test_clr();
        clr = 1'b1;
        step();
        checks++;
        if (err_v !== 1'b0 || irq !== 1'b0 || lost !== 8'd0 || lost2 !== 2'd0 || reqaddr !== 32'h80) begin
            errors++;
            $display("FAIL clr_alone: v=%0b irq=%0b lost=%0d lost2=%0d addr=%h, required 0 0 0 0 00000080",
                     err_v, irq, lost, lost2, reqaddr);
        end
        clr = 1'b1;
        step();
        checks++;
        if (err_v !== 1'b0 || lost !== 8'd0 || ttype !== 2'd3) begin
            errors++;
            $display("FAIL clr_idle_noop: v=%0b lost=%0d ttype=%0d, required 0 0 3", err_v, lost, ttype);
        end
        rd_v = 1'b1; rd_ttype = 2'd1; rd_etype = 3'd1; rd_addr = 64'h4_0000_0044; rd_rrid = 16'hBEEF; rd_eid = 16'd12;
        step();
        checks++;
        if (err_v !== 1'b1 || irq !== 1'b1 || ttype !== 2'd1 || etype !== 3'd1 || reqaddr !== 32'h44 ||
            reqaddrh !== 32'h4 || rrid !== 16'hBEEF || eid !== 16'd12 || lost !== 8'd0) begin
            errors++;
            $display("FAIL rd_after_clr: v=%0b irq=%0b ttype=%0d etype=%0d addr=%h_%h rrid=%h eid=%0d lost=%0d, required 1 1 1 1 00000004_00000044 beef 12 0",
                     err_v, irq, ttype, etype, reqaddrh, reqaddr, rrid, eid, lost);
        end
    endtask

`ifdef RV_IOPMP_ERR_MSI_EN
    task automatic test_msi();
        apply_reset();
        ie = 1'b1; msi_en = 1'b1; msi_addr_in = 64'h1000; msi_data_in = 11'h02A;
        wr_v = 1'b1; wr_etype = 3'd3; wr_addr = 64'h5000; wr_rrid = 16'd1; wr_eid = 16'd2;
        step();
        msi_addr_in = 64'hDEAD_0000; msi_data_in = 11'h155;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (msi_req !== 1'b1 || msi_addr !== 64'h1000 || msi_data !== 11'h02A || irq !== 1'b0 || err_v !== 1'b1) begin
                errors++;
                $display("FAIL msi_pending[%0d]: req=%0b addr=%h data=%h irq=%0b v=%0b, required 1 1000 02a 0 1",
                         i, msi_req, msi_addr, msi_data, irq, err_v);
            end
            if (i == 3) msi_ack = 1'b1;
            step();
        end
        msi_ack = 1'b0;
        checks++;
        if (msi_req !== 1'b0 || irq !== 1'b0 || err_v !== 1'b1) begin
            errors++;
            $display("FAIL msi_done: req=%0b irq=%0b v=%0b, required 0 0 1", msi_req, irq, err_v);
        end
        msi_en = 1'b0;
        #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL msi_off_irq: irq=%0b, required 1", irq);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; wr_v = 1'b0; rd_v = 1'b0; ie = 1'b0; clr = 1'b0;
        wr_etype = 3'd0; rd_etype = 3'd0; rd_ttype = 2'd0;
        wr_addr = 64'd0; rd_addr = 64'd0; wr_rrid = 16'd0; rd_rrid = 16'd0; wr_eid = 16'd0; rd_eid = 16'd0;
`ifdef RV_IOPMP_ERR_MSI_EN
        msi_en = 1'b0; msi_ack = 1'b0; msi_addr_in = 64'd0; msi_data_in = 11'd0;
`endif
        test_reset();
        test_capture();
        test_async_reset();
        test_simultaneous();
        test_clr_with_valid();
        test_saturation();
        test_clr();
`ifdef RV_IOPMP_ERR_MSI_EN
        test_msi();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
